cim_row_sequencer: RTL and testbench

Parametrised word-line driver and sequencer for the CIM macro array. It generalises the 4-row row decoder to `ROWS` rows, and accepts operations through a valid/ready handshake. Each operation runs for a programmed pulse width. MAC reads can step automatically through a burst of consecutive rows, with a break-before-make gap between rows. It drives the active-low `WL_bar`/`WLB_bar` buses and sits between the macro controller and the bit-cell array.

---
 rtl/cim_row_sequencer.sv | 148 ++++++++++++++
 tb/tb_cim_row_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cim_row_sequencer.sv
// rtl/cim_row_sequencer.sv - word-line sequencer for the CIM array: valid/ready ops, timed pulses, MAC row bursts
`timescale 1ns/1ps
module cim_row_sequencer #(
  parameter int ROWS      = 16,
  parameter int ADDR_W    = $clog2(ROWS),
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic              clk,
  input  logic              cs,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] burst_len,
  input  logic [ROWS-1:0]   data,
  output logic [ROWS-1:0]   WL_bar,
  output logic [ROWS-1:0]   WLB_bar,
  output logic [ADDR_W-1:0] cur_row,
  output logic              row_strobe,
  output logic              done,
  output logic              busy
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [1:0]        mode_q, mode_d;
  logic [ROWS-1:0]   data_q, data_d;
  logic [ADDR_W-1:0] cur_row_q, cur_row_d;
  logic [ROWS-1:0]   wl_bar_q, wl_bar_d;
  logic [ROWS-1:0]   wlb_bar_q, wlb_bar_d;
  logic              row_strobe_q, row_strobe_d;

  // Returns {WL_bar, WLB_bar} for one pulse of the given mode and row.
  function automatic logic [2*ROWS-1:0] drive_bar(input logic [1:0] m,
                                                  input logic [ADDR_W-1:0] row,
                                                  input logic [ROWS-1:0] pat);
    logic [ROWS-1:0] onehot;
    logic [ROWS-1:0] wl;
    logic [ROWS-1:0] wlb;
    onehot      = '0;
    onehot[row] = 1'b1;
    case (m)
      2'b00:   begin wl = onehot; wlb = onehot; end
      2'b01:   begin wl = onehot; wlb = '0;     end
      2'b10:   begin wl = '0;     wlb = onehot; end
      default: begin wl = pat;    wlb = ~pat;   end
    endcase
    return {~wl, ~wlb};
  endfunction

  always_ff @(posedge clk or negedge cs) begin
    if (!cs) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      mode_q       <= 2'b00;
      data_q       <= '0;
      cur_row_q    <= '0;
      wl_bar_q     <= '1;
      wlb_bar_q    <= '1;
      row_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      mode_q       <= mode_d;
      data_q       <= data_d;
      cur_row_q    <= cur_row_d;
      wl_bar_q     <= wl_bar_d;
      wlb_bar_q    <= wlb_bar_d;
      row_strobe_q <= row_strobe_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    mode_d       = mode_q;
    data_d       = data_q;
    cur_row_d    = cur_row_q;
    wl_bar_d     = wl_bar_q;
    wlb_bar_d    = wlb_bar_q;
    row_strobe_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          mode_d                 = mode;
          data_d                 = data;
          cur_row_d              = addr;
          rem_d                  = (mode == 2'b01 || mode == 2'b10) ? burst_len : '0;
          cnt_d                  = PULSE_LOAD;
          {wl_bar_d, wlb_bar_d}  = drive_bar(mode, addr, data);
          row_strobe_d           = 1'b1;
          state_d                = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          wl_bar_d  = '1;
          wlb_bar_d = '1;
          // rem_q can only be non-zero for MAC modes
          if (rem_q != '0) begin
            cnt_d   = GAP_LOAD;
            rem_d   = rem_q - 1'b1;
            state_d = S_GAP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cur_row_d              = cur_row_q + 1'b1;
          cnt_d                  = PULSE_LOAD;
          {wl_bar_d, wlb_bar_d}  = drive_bar(mode_q, cur_row_d, data_q);
          row_strobe_d           = 1'b1;
          state_d                = S_PULSE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE) && cs;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    WL_bar     = wl_bar_q;
    WLB_bar    = wlb_bar_q;
    cur_row    = cur_row_q;
    row_strobe = row_strobe_q;
  end

endmodule

// File: tb/tb_cim_row_sequencer.sv
// tb/tb_cim_row_sequencer.sv - bench for cim_row_sequencer: vector table, reference traces, random ops, abort
`timescale 1ns/1ps
module tb_cim_row_sequencer;

  localparam int ROWS = 16;
  localparam int AW   = 4;
  localparam int P    = 2;
  localparam int G    = 1;

  logic            clk = 1'b0;
  logic            cs = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      mode = 2'b00;
  logic [AW-1:0]   addr = '0;
  logic [AW-1:0]   burst_len = '0;
  logic [ROWS-1:0] data = '0;
  logic [ROWS-1:0] WL_bar;
  logic [ROWS-1:0] WLB_bar;
  logic [AW-1:0]   cur_row;
  logic            row_strobe;
  logic            done;
  logic            busy;

  cim_row_sequencer #(.ROWS(ROWS), .ADDR_W(AW), .PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk(clk), .cs(cs), .req_valid(req_valid), .req_ready(req_ready),
    .mode(mode), .addr(addr), .burst_len(burst_len), .data(data),
    .WL_bar(WL_bar), .WLB_bar(WLB_bar), .cur_row(cur_row),
    .row_strobe(row_strobe), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] wl_bar;
    logic [15:0] wlb_bar;
    logic        strobe;
    logic        dn;
    logic [3:0]  row;
  } cyc_t;

  typedef struct {
    logic [1:0]  m;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] d;
    logic [15:0] wl0;
    logic [15:0] wlb0;
    int          dlat;
  } vec_t;

  cyc_t exp_q[$];
  vec_t vt[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected per-cycle trace from the accept cycle through the done cycle.
  function automatic void build(input logic [1:0] m, input logic [3:0] a,
                                input logic [3:0] b, input logic [15:0] d);
    int          n;
    logic [15:0] oh;
    logic [15:0] wl;
    logic [15:0] wlb;
    logic [3:0]  row;
    cyc_t        c;
    exp_q.delete();
    n   = (m == 2'b01 || m == 2'b10) ? int'(b) + 1 : 1;
    row = a;
    for (int r = 0; r < n; r++) begin
      row = 4'((int'(a) + r) % ROWS);
      oh  = 16'(1) << row;
      case (m)
        2'b00:   begin wl = oh;    wlb = oh;    end
        2'b01:   begin wl = oh;    wlb = 16'h0; end
        2'b10:   begin wl = 16'h0; wlb = oh;    end
        default: begin wl = d;     wlb = ~d;    end
      endcase
      for (int p = 0; p < P; p++) begin
        c = '{wl_bar: ~wl, wlb_bar: ~wlb, strobe: (p == 0), dn: 1'b0, row: row};
        exp_q.push_back(c);
      end
      if (r < n - 1) begin
        for (int g = 0; g < G; g++) begin
          c = '{wl_bar: 16'hFFFF, wlb_bar: 16'hFFFF, strobe: 1'b0, dn: 1'b0, row: row};
          exp_q.push_back(c);
        end
      end
    end
    c = '{wl_bar: 16'hFFFF, wlb_bar: 16'hFFFF, strobe: 1'b0, dn: 1'b1, row: row};
    exp_q.push_back(c);
  endfunction

  // Called mid-cycle with the DUT idle; returns mid-cycle in the idle cycle after done.
  task automatic do_op(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                       input logic [15:0] d, input bit hold, input string tag,
                       output logic [15:0] first_wl, output logic [15:0] first_wlb,
                       output int done_at);
    mode      = m;
    addr      = a;
    burst_len = b;
    data      = d;
    req_valid = 1'b1;
    check($sformatf("%s ready_pre", tag), 64'(req_ready), 64'd1);
    build(m, a, b, d);
    done_at = -1;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    first_wl  = WL_bar;
    first_wlb = WLB_bar;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("%s c%0d", tag, i),
            64'({WL_bar, WLB_bar, row_strobe, done, cur_row, busy, req_ready}),
            64'({exp_q[i], 2'b10}));
      if (done && done_at < 0) done_at = i;
    end
    @(posedge clk); #1;
    check($sformatf("%s idle", tag), 64'({WL_bar, WLB_bar, busy, done, req_ready}),
          64'({32'hFFFF_FFFF, 3'b001}));
  endtask

  logic [15:0] fw;
  logic [15:0] fwb;
  int          dl;

  initial begin
    vt[0] = '{2'b00, 4'd5,  4'd0, 16'h0000, 16'hFFDF, 16'hFFDF, 2};
    vt[1] = '{2'b10, 4'd14, 4'd2, 16'h0000, 16'hFFFF, 16'hBFFF, 8};
    vt[2] = '{2'b11, 4'd7,  4'd3, 16'hA5C3, 16'h5A3C, 16'hA5C3, 2};
    vt[3] = '{2'b01, 4'd0,  4'd0, 16'h1234, 16'hFFFE, 16'hFFFF, 2};
    vt[4] = '{2'b01, 4'd15, 4'd1, 16'h0000, 16'h7FFF, 16'hFFFF, 5};
    vt[5] = '{2'b00, 4'd15, 4'd7, 16'hFFFF, 16'h7FFF, 16'h7FFF, 2};

    #12;
    check("reset outs", 64'({WL_bar, WLB_bar, cur_row, row_strobe, done, busy, req_ready}),
          64'({32'hFFFF_FFFF, 4'd0, 4'b0000}));
    @(posedge clk); #1;
    cs = 1'b1;
    #1;
    check("ready after cs", 64'({req_ready, busy}), 64'(2'b10));

    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].m, vt[i].a, vt[i].b, vt[i].d, 1'b0, $sformatf("vec%0d", i), fw, fwb, dl);
      check($sformatf("vec%0d wl0", i),  64'(fw),  64'(vt[i].wl0));
      check($sformatf("vec%0d wlb0", i), 64'(fwb), 64'(vt[i].wlb0));
      check($sformatf("vec%0d done_lat", i), 64'(dl), 64'(vt[i].dlat));
    end

    do_op(2'b01, 4'd2, 4'd1, 16'h0, 1'b1, "b2b_a", fw, fwb, dl);
    do_op(2'b01, 4'd9, 4'd0, 16'h0, 1'b0, "b2b_b", fw, fwb, dl);
    check("b2b_b done_lat", 64'(dl), 64'd2);

    mode = 2'b01; addr = 4'd3; burst_len = 4'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort mid", 64'({WL_bar, busy}), 64'({16'hFFEF, 1'b1}));
    #2;
    cs = 1'b0;
    #1;
    check("abort async", 64'({WL_bar, WLB_bar, busy, done, req_ready, row_strobe, cur_row}),
          64'({32'hFFFF_FFFF, 8'h00}));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort hold%0d", i), 64'({WL_bar, WLB_bar, busy, done}),
            64'({32'hFFFF_FFFF, 2'b00}));
    end
    cs = 1'b1;
    #1;
    check("abort ready", 64'(req_ready), 64'd1);
    do_op(2'b10, 4'd1, 4'd1, 16'h0, 1'b0, "post_abort", fw, fwb, dl);
    check("post_abort done_lat", 64'(dl), 64'd5);

    for (int k = 0; k < 25; k++) begin
      logic [1:0]  rm;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [15:0] rd;
      bit          rh;
      rm = 2'($urandom_range(0, 3));
      ra = 4'($urandom);
      rb = 4'($urandom_range(0, 3));
      rd = 16'($urandom);
      rh = 1'($urandom_range(0, 1));
      do_op(rm, ra, rb, rd, rh, $sformatf("rnd%0d", k), fw, fwb, dl);
      if (!rh) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          check($sformatf("rnd%0d gap", k), 64'({WL_bar, WLB_bar, busy, req_ready}),
                64'({32'hFFFF_FFFF, 2'b01}));
        end
      end
    end
    req_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
